// File: rtl/counter_8bit_pkg.sv
// Shared constants for the up/down wrap counter.
package counter_8bit_pkg;

  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

endpackage : counter_8bit_pkg

// File: rtl/counter_8bit.sv
// Up/down counter with modulo wrap and a registered one-cycle wrap pulse.
module counter_8bit
  import counter_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Wrap is detected on the pre-step value so the flag lands on the same edge as the wrapped count.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (enable) begin
      if (up_down) begin
        count_d    = count_q + ONE;
        overflow_d = (count_q == '1);
      end else begin
        count_d    = count_q - ONE;
        overflow_d = (count_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule : counter_8bit

// File: tb/tb_counter_8bit.sv
// Scoreboard bench for counter_8bit: expected values queued at drive time, compared after each edge.
module tb_counter_8bit;
  import counter_8bit_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 enable = 1'b0;
  logic                 up_down = 1'b0;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int          mdl_cnt = 0;
  int          mdl_ovf = 0;
  int          exp_cnt_q[$];
  int          exp_ovf_q[$];

  counter_8bit #(.WIDTH(CNT_WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .up_down  (up_down),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic r, input logic en, input logic ud, input string tag);
    int exp_c, exp_o;
    @(negedge clk);
    rst     = r;
    enable  = en;
    up_down = ud;
    if (r) begin
      mdl_cnt = 0;
      mdl_ovf = 0;
    end else if (en && ud) begin
      mdl_ovf = (mdl_cnt == 255) ? 1 : 0;
      mdl_cnt = (mdl_cnt + 1) % 256;
    end else if (en) begin
      mdl_ovf = (mdl_cnt == 0) ? 1 : 0;
      mdl_cnt = (mdl_cnt + 255) % 256;
    end else begin
      mdl_ovf = 0;
    end
    exp_cnt_q.push_back(mdl_cnt);
    exp_ovf_q.push_back(mdl_ovf);
    @(posedge clk);
    #1;
    if (exp_cnt_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 1, 0);
    end else begin
      exp_c = exp_cnt_q.pop_front();
      exp_o = exp_ovf_q.pop_front();
      chk({tag, "_count"}, int'(count), exp_c);
      chk({tag, "_ovf"}, int'(overflow), exp_o);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Reset wins over enable
    step(1'b1, 1'b1, 1'b1, "reset");
    chk("reset_const_count", int'(count), 0);
    chk("reset_const_ovf", int'(overflow), 0);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, "up");
    chk("up10_count", int'(count), 10);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, logic'(i % 2), "hold");
    chk("hold_count", int'(count), 10);
    chk("hold_ovf", int'(overflow), 0);

    // Reach 250 via a down-wrap from 0
    step(1'b1, 1'b0, 1'b0, "rst2");
    step(1'b0, 1'b1, 1'b0, "dn_wrap0");
    chk("first_down_count", int'(count), 255);
    chk("first_down_ovf", int'(overflow), 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, "dn_to250");
    chk("at250", int'(count), 250);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, "up_to255");
    chk("at255_count", int'(count), 255);
    chk("at255_ovf", int'(overflow), 0);
    step(1'b0, 1'b1, 1'b1, "up_wrap");
    chk("upwrap_count", int'(count), 0);
    chk("upwrap_ovf", int'(overflow), 1);
    step(1'b0, 1'b1, 1'b1, "after_upwrap");
    chk("after_upwrap_count", int'(count), 1);
    chk("after_upwrap_ovf", int'(overflow), 0);

    step(1'b1, 1'b0, 1'b1, "rst3");
    step(1'b0, 1'b1, 1'b0, "dnwrap");
    chk("dnwrap_count", int'(count), 255);
    chk("dnwrap_ovf", int'(overflow), 1);
    step(1'b0, 1'b1, 1'b0, "after_dnwrap");
    chk("after_dnwrap_count", int'(count), 254);
    chk("after_dnwrap_ovf", int'(overflow), 0);

    step(1'b1, 1'b0, 1'b0, "rst4");
    for (int i = 0; i < 37; i++) step(1'b0, 1'b1, 1'b1, "up_to37");
    chk("at37", int'(count), 37);
    step(1'b1, 1'b1, 1'b1, "midrst");
    chk("midrst_count", int'(count), 0);
    step(1'b0, 1'b1, 1'b1, "post_midrst");
    chk("post_midrst_count", int'(count), 1);

    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)), "rand");
    end

    chk("sb_empty", exp_cnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_counter_8bit
